// File: rtl/lsu_align.sv
// Load/store alignment unit: turns one byte-addressed request into one or two
// word-aligned memory accesses and returns an extended load result.
module lsu_align #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [63:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_legal;
    logic        req_mis;
    logic [1:0]  off;
    logic [3:0]  size_mask;
    logic [7:0]  be_wide;
    logic        crosses;
    logic [63:0] wdata_wide;
    logic [63:0] buf_sample;
    logic [31:0] load_raw;
    logic [31:0] load_ext;

    always_comb begin
        req_legal = (req_funct3[1:0] != 2'b11) &&
                    (req_we ? !req_funct3[2] : (req_funct3[2:1] != 2'b11));
        req_mis   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Everything below is decoded from the captured request only.
    assign off = addr_q[1:0];

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign be_wide    = {4'b0000, size_mask} << off;
    assign crosses    = |be_wide[7:4];
    assign wdata_wide = {32'h0, wdata_q} << {off, 3'b000};

    // Buffer as it will look after this cycle's read data is captured.
    assign buf_sample = (state_q == S_ACC1) ? {mem_rdata, buf_q[31:0]}
                                            : {buf_q[63:32], mem_rdata};
    assign load_raw   = 32'(buf_sample >> {off, 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{load_raw[7]}}, load_raw[7:0]};
            3'b001:  load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
            3'b100:  load_ext = {24'h0, load_raw[7:0]};
            3'b101:  load_ext = {16'h0, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        buf_d     = buf_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                rdata_d   = 32'h0;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = !req_legal || (!ALLOW_MISALIGNED && req_mis);
                    state_d  = (!req_legal || (!ALLOW_MISALIGNED && req_mis)) ? S_RESP : S_ACC0;
                end
            end
            S_ACC0: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = we_q;
                mem_be    = be_wide[3:0];
                mem_wdata = wdata_wide[31:0];
                buf_d     = buf_sample;
                if (crosses) begin
                    state_d = S_ACC1;
                end else begin
                    state_d = S_RESP;
                    rdata_d = we_q ? 32'h0 : load_ext;
                end
            end
            S_ACC1: begin
                mem_addr  = {addr_q[31:2] + 30'd1, 2'b00};
                mem_we    = we_q;
                mem_be    = be_wide[7:4];
                mem_wdata = wdata_wide[63:32];
                buf_d     = buf_sample;
                state_d   = S_RESP;
                rdata_d   = we_q ? 32'h0 : load_ext;
            end
            default: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign rsp_err   = (state_q == S_RESP) && err_q;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            buf_q    <= 64'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: one instance per ALLOW_MISALIGNED setting, sharing the
// request bus, each with its own memory and a byte-level reference model.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        ready [2];
    logic        rv    [2];
    logic        re    [2];
    logic        mwe   [2];
    logic [31:0] rd    [2];
    logic [31:0] maddr [2];
    logic [31:0] mwd   [2];
    logic [31:0] mrd   [2];
    logic [3:0]  mbe   [2];

    logic [31:0] mem  [2][64];
    logic [7:0]  refm [2][256];

    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_data = 32'h0;

    logic [31:0] t_addr [2][6];
    logic [31:0] t_wd   [2][6];
    logic [31:0] t_rd   [2][6];
    logic [3:0]  t_be   [2][6];
    logic        t_we   [2][6];
    logic        t_rv   [2][6];
    logic        t_err  [2][6];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            lsu_align #(.ALLOW_MISALIGNED(gi == 1)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .req_valid  (req_valid),
                .req_ready  (ready[gi]),
                .req_we     (req_we),
                .req_funct3 (req_funct3),
                .req_addr   (req_addr),
                .req_wdata  (req_wdata),
                .rsp_valid  (rv[gi]),
                .rsp_err    (re[gi]),
                .rsp_rdata  (rd[gi]),
                .mem_addr   (maddr[gi]),
                .mem_we     (mwe[gi]),
                .mem_be     (mbe[gi]),
                .mem_wdata  (mwd[gi]),
                .mem_rdata  (mrd[gi])
            );
            assign mrd[gi] = mem[gi][maddr[gi][7:2]];
        end
    endgenerate

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (poke_en)
                mem[d][poke_idx] <= poke_data;
            else if (mwe[d])
                for (int b = 0; b < 4; b++)
                    if (mbe[d][b]) mem[d][maddr[d][7:2]][b*8 +: 8] <= mwd[d][b*8 +: 8];
        end
    end

    task automatic poke(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        poke_en = 1'b1;
        poke_idx = idx;
        poke_data = data;
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 4; b++) refm[d][{idx, 2'(b)}] = data[b*8 +: 8];
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic sample(input int k);
        for (int d = 0; d < 2; d++) begin
            t_addr[d][k] = maddr[d];
            t_wd[d][k]   = mwd[d];
            t_rd[d][k]   = rd[d];
            t_be[d][k]   = mbe[d];
            t_we[d][k]   = mwe[d];
            t_rv[d][k]   = rv[d];
            t_err[d][k]  = re[d];
        end
    endtask

    // Reference: size/offset rules applied byte by byte to a byte-array memory.
    task automatic check_dut(input int d, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, output int lat);
        int size, off, nacc;
        logic legal, mis, err;
        logic [3:0] ebe [2];
        logic [31:0] ewd [2];
        logic [31:0] ba, val, eaddr, exp_rd;
        off = int'(a[1:0]);
        case (f3[1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            2'b10:   size = 4;
            default: size = 0;
        endcase
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (size == 2 && (off % 2) == 1) || (size == 4 && off != 0);
        err   = !legal || (d == 0 && mis);
        nacc  = err ? 0 : ((off + size > 4) ? 2 : 1);
        lat   = nacc + 1;
        ebe[0] = 4'b0000;
        ebe[1] = 4'b0000;
        val = 32'h0;
        for (int i = 0; i < size; i++) begin
            ba = a + 32'(i);
            ebe[(ba[31:2] != a[31:2]) ? 1 : 0][ba[1:0]] = 1'b1;
            val = val | (32'(refm[d][ba[7:0]]) << (8 * i));
        end
        if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
        if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
        ewd[0] = wd << (8 * off);
        ewd[1] = (off == 0) ? 32'h0 : (wd >> (8 * (4 - off)));
        exp_rd = (we || err) ? 32'h0 : val;
        for (int k = 1; k <= 5; k++) begin
            eaddr = {a[31:2], 2'b00} + 32'((k - 1) * 4);
            checks++;
            if (k <= nacc) begin
                if ({t_addr[d][k], t_we[d][k], t_be[d][k], t_wd[d][k]} !== {eaddr, we, ebe[k-1], ewd[k-1]}) begin
                    errors++;
                    $display("FAIL mem_access dut%0d cyc%0d got addr=%08h we=%b be=%b wd=%08h want addr=%08h we=%b be=%b wd=%08h",
                             d, k, t_addr[d][k], t_we[d][k], t_be[d][k], t_wd[d][k], eaddr, we, ebe[k-1], ewd[k-1]);
                end
            end else if ({t_addr[d][k], t_we[d][k], t_be[d][k], t_wd[d][k]} !== 69'h0) begin
                errors++;
                $display("FAIL mem_idle dut%0d cyc%0d got addr=%08h we=%b be=%b wd=%08h want all zero",
                         d, k, t_addr[d][k], t_we[d][k], t_be[d][k], t_wd[d][k]);
            end
            checks++;
            if (t_rv[d][k] !== (k == lat)) begin
                errors++;
                $display("FAIL rsp_valid dut%0d cyc%0d got %b want %b", d, k, t_rv[d][k], (k == lat));
            end
            if (k == lat) begin
                checks++;
                if ({t_err[d][k], t_rd[d][k]} !== {err, exp_rd}) begin
                    errors++;
                    $display("FAIL rsp_data dut%0d got err=%b rdata=%08h want err=%b rdata=%08h",
                             d, t_err[d][k], t_rd[d][k], err, exp_rd);
                end
            end
        end
        if (we && !err)
            for (int i = 0; i < size; i++) begin
                ba = a + 32'(i);
                refm[d][ba[7:0]] = wd[i*8 +: 8];
            end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int lat0, lat1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL ready_before_req dut%0d got %b want 1", d, ready[d]);
            end
        end
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        // A request held during a busy cycle must be ignored.
        req_we = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 1) req_valid = 1'b0;
        end
        check_dut(0, we, f3, a, wd, lat0);
        check_dut(1, we, f3, a, wd, lat1);
        $display("txn we=%0b f3=%03b addr=%08h wdata=%08h | allow1 lat=%0d rdata=%08h err=%0b | allow0 lat=%0d rdata=%08h err=%0b",
                 we, f3, a, wd, lat1, t_rd[1][lat1], t_err[1][lat1], lat0, t_rd[0][lat0], t_err[0][lat0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ready[d], rv[d], re[d], rd[d], maddr[d], mwe[d], mbe[d], mwd[d]} !== {1'b1, 103'h0}) begin
                errors++;
                $display("FAIL reset_state dut%0d got ready=%b rv=%b err=%b rdata=%08h addr=%08h we=%b be=%b wd=%08h want ready=1 rest 0",
                         d, ready[d], rv[d], re[d], rd[d], maddr[d], mwe[d], mbe[d], mwd[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset dut%0d got %b want 1", d, ready[d]);
            end
        end
    endtask

    task automatic test_directed();
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({t_addr[1][1], t_be[1][1], t_wd[1][1], t_we[1][1], t_rv[1][2], t_rd[1][2]} !==
            {32'h10, 4'b1111, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL sw_aligned got addr=%08h be=%b wd=%08h we=%b rv2=%b rdata=%08h",
                     t_addr[1][1], t_be[1][1], t_wd[1][1], t_we[1][1], t_rv[1][2], t_rd[1][2]);
        end
        do_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
        checks++;
        if ({t_be[1][1], t_wd[1][1]} !== {4'b1000, 32'hA5000000}) begin
            errors++;
            $display("FAIL sb_lane3 got be=%b wd=%08h want be=1000 wd=a5000000", t_be[1][1], t_wd[1][1]);
        end
        do_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF);
        checks++;
        if ({t_be[1][1], t_wd[1][1]} !== {4'b1100, 32'hBEEF0000}) begin
            errors++;
            $display("FAIL sh_upper got be=%b wd=%08h want be=1100 wd=beef0000", t_be[1][1], t_wd[1][1]);
        end
        poke(6'h08, 32'h80011234);
        poke(6'h03, 32'h44332211);
        poke(6'h04, 32'h88776655);
        do_req(1'b0, 3'b001, 32'h22, 32'h0);
        checks++;
        if (t_rd[1][2] !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh_sign got %08h want ffff8001", t_rd[1][2]);
        end
        do_req(1'b0, 3'b101, 32'h22, 32'h0);
        checks++;
        if (t_rd[1][2] !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu_zero got %08h want 00008001", t_rd[1][2]);
        end
        do_req(1'b0, 3'b000, 32'h21, 32'h0);
        checks++;
        if (t_rd[1][2] !== 32'h00000012) begin
            errors++;
            $display("FAIL lb_pos got %08h want 00000012", t_rd[1][2]);
        end
        do_req(1'b0, 3'b100, 32'h23, 32'h0);
        checks++;
        if (t_rd[1][2] !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu got %08h want 00000080", t_rd[1][2]);
        end
        do_req(1'b0, 3'b010, 32'h0E, 32'h0);
        checks++;
        if ({t_addr[1][1], t_addr[1][2], t_rv[1][3], t_rd[1][3]} !== {32'h0C, 32'h10, 1'b1, 32'h66554433}) begin
            errors++;
            $display("FAIL lw_split got a0=%08h a1=%08h rv3=%b rdata=%08h want 0c 10 1 66554433",
                     t_addr[1][1], t_addr[1][2], t_rv[1][3], t_rd[1][3]);
        end
        checks++;
        if ({t_rv[0][1], t_err[0][1], t_rd[0][1], t_we[0][1], t_be[0][1]} !== {1'b1, 1'b1, 32'h0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL lw_misaligned_err got rv=%b err=%b rdata=%08h we=%b be=%b",
                     t_rv[0][1], t_err[0][1], t_rd[0][1], t_we[0][1], t_be[0][1]);
        end
        do_req(1'b1, 3'b010, 32'h0F, 32'h11223344);
        checks++;
        if ({t_be[1][1], t_wd[1][1], t_addr[1][2], t_be[1][2], t_wd[1][2]} !==
            {4'b1000, 32'h44000000, 32'h10, 4'b0111, 32'h00112233}) begin
            errors++;
            $display("FAIL sw_split got be0=%b wd0=%08h a1=%08h be1=%b wd1=%08h",
                     t_be[1][1], t_wd[1][1], t_addr[1][2], t_be[1][2], t_wd[1][2]);
        end
        do_req(1'b0, 3'b011, 32'h0, 32'h0);
        checks++;
        if ({t_err[0][1], t_err[1][1], t_rv[0][1], t_rv[1][1]} !== 4'b1111) begin
            errors++;
            $display("FAIL illegal_funct3 got err0=%b err1=%b rv0=%b rv1=%b want all 1",
                     t_err[0][1], t_err[1][1], t_rv[0][1], t_rv[1][1]);
        end
        do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        checks++;
        if ({t_addr[1][1], t_addr[1][2]} !== {32'hFFFFFFFC, 32'h0}) begin
            errors++;
            $display("FAIL addr_wrap got a0=%08h a1=%08h want fffffffc 00000000", t_addr[1][1], t_addr[1][2]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h0F;
        req_wdata = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({mwe[1], maddr[1]} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL reset_mid_acc1 got we=%b addr=%08h want 1 00000010", mwe[1], maddr[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mwe[1], mbe[1]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_async_drop got we=%b be=%b want 0 0000", mwe[1], mbe[1]);
        end
        refm[1][8'h0F] = 8'h44;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) rst_n = 1'b1;
            checks++;
            if ({rv[0], rv[1]} !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_rsp cyc%0d got rv0=%b rv1=%b want 0 0", k, rv[0], rv[1]);
            end
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        checks++;
        if (t_rv[1][2] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_lw got rv2=%b want 1", t_rv[1][2]);
        end
    endtask

    task automatic test_random();
        logic [2:0] f3;
        logic we;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) == 1 ? 3'b100 : 3'b000);
            if (f3 == 3'b110) f3 = 3'b100;
            do_req(we, f3, $urandom, $urandom);
        end
    endtask

    task automatic test_memory();
        logic [31:0] expw;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++) begin
                expw = {refm[d][w*4+3], refm[d][w*4+2], refm[d][w*4+1], refm[d][w*4]};
                checks++;
                if (mem[d][w] !== expw) begin
                    errors++;
                    $display("FAIL mem_contents dut%0d word%0d got %08h want %08h", d, w, mem[d][w], expw);
                end
            end
    endtask

    initial begin
        test_reset();
        for (int w = 0; w < 64; w++) poke(6'(w), $urandom);
        test_directed();
        test_reset_mid();
        test_random();
        test_memory();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit in the MEM stage, directly upstream of data memory.
- Accepts one load/store request from the EX/MEM pipeline register through a valid/ready handshake.
- Generates word-aligned memory accesses with per-byte write enables.
- Splits word-crossing accesses into two memory cycles, then returns a sign/zero-extended load result or store completion to the pipeline.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split word-crossing accesses into two accesses; 0 = report any non-naturally-aligned access as an error with no memory access.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-justified
- rsp_valid  output  1  one-cycle completion pulse
- rsp_err  output  1  misaligned (ALLOW_MISALIGNED=0) or illegal funct3; valid with rsp_valid
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- mem_addr  output  32  word-aligned byte address, bits [1:0] always 00
- mem_we  output  1  memory write strobe
- mem_be  output  4  byte enables; bit i = byte lane i, little-endian
- mem_wdata  output  32  lane-positioned write data
- mem_rdata  input  32  memory read data for mem_addr, combinational, same cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- States:
  - IDLE: req_ready=1. On req_valid, capture we/funct3/addr/wdata.
    - Illegal funct3 (011, 11x for loads; anything except 000–010 for stores), or misaligned with ALLOW_MISALIGNED=0, goes to RESP with error flag set.
    - Otherwise goes to ACC0.
  - ACC0: first word access. Goes to ACC1 if the access crosses a word boundary, else to RESP.
  - ACC1: second word access, then RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- req_ready=1 only in IDLE. Requests presented in other states are ignored.
- Latency, with acceptance edge at cycle T:
  - Aligned: ACC0 at T+1, rsp at T+2.
  - Split: ACC0 at T+1, ACC1 at T+2, rsp at T+3.
  - Error: rsp at T+1, no mem_we, mem_be=0 throughout.
- Sizes and offset: size = 1/2/4 bytes; off = addr[1:0].
  - Natural alignment: halfword needs off[0]=0; word needs off=00.
  - Crossing: off+size>4. Only lh/lhu/sh at off=3 and lw/sw at off≠0 cross.
  - Halfword at off=1 is misaligned but does not cross. It takes one access when ALLOW_MISALIGNED=1 and is an error when 0.
- ACC0 outputs:
  - mem_addr = {addr[31:2],00}.
  - mem_be = (size mask << off)[3:0].
  - mem_wdata = wdata << 8*off.
- ACC1 outputs:
  - mem_addr = {addr[31:2]+1,00}, wrapping 0xFFFFFFFC→0x00000000.
  - mem_be = (size mask << off)[7:4].
  - mem_wdata = wdata >> 8*(4−off).
- Write strobe: mem_we = captured we in ACC0/ACC1 only.
- Idle memory port: in IDLE and RESP, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. Outputs are decoded from state and captured registers only, never from req_*.
- Load assembly:
  - mem_rdata is sampled at the end of ACC0 into buffer bits [31:0] and at the end of ACC1 into bits [63:32].
  - Raw = buffer >> 8*off.
  - lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes through.
  - rsp_rdata is registered and held stable during RESP.
- Stores: rsp_rdata=0.
- Reset values: state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, all mem_* outputs 0, buffer 0. req_ready=1 immediately after reset.
- Reset mid-operation (any state):
  - mem_we and mem_be drop asynchronously.
  - The pending response is discarded and never emitted.
  - A split store interrupted after ACC0 leaves the first word written. This is accepted behaviour.

Test Plan:
- sw 0xDEADBEEF @0x10 → T+1: mem_addr=0x10, be=1111, mem_wdata=0xDEADBEEF, mem_we=1. T+2: rsp_valid=1, err=0, rdata=0.
- sb wdata=0x000000A5 @0x13 → be=1000, mem_wdata=0xA5000000, single access. sh 0xBEEF @0x12 → be=1100, mem_wdata=0xBEEF0000.
- mem[0x20]=0x80011234: lh @0x22 → rdata=0xFFFF8001; lhu @0x22 → 0x00008001; lb @0x21 → 0x00000012; lbu @0x23 → 0x00000080.
- ALLOW_MISALIGNED=1, mem[0x0C]=0x44332211, mem[0x10]=0x88776655: lw @0x0E → ACC0 addr 0x0C, ACC1 addr 0x10, rsp at T+3 with rdata=0x66554433. sw 0x11223344 @0x0F → ACC0 addr 0x0C be=1000 wdata=0x44000000; ACC1 addr 0x10 be=0111 wdata=0x00112233.
- ALLOW_MISALIGNED=0: lw @0x0E → rsp_valid at T+1, err=1, rdata=0, mem_we never 1. funct3=011 load @0x0 → err=1 in either mode. lw @0xFFFFFFFE with ALLOW=1 → ACC1 mem_addr=0x00000000.
- Assert rst_n low during ACC1 of a split sw → mem_we=0 immediately, no rsp_valid. After release, req_ready=1 and the next lw @0x10 completes normally at T+2.
